// File: rtl/dmem_responder_if.sv
// Data-memory port between the core (master) and the memory responder (slave).
interface dmem_responder_if;
  localparam int unsigned ADDR_W = 32;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned BE_W   = 4;

  logic [ADDR_W-1:0] dcache_addr;
  logic [BE_W-1:0]   dcache_we;
  logic              dcache_re;
  logic [DATA_W-1:0] dcache_din;
  logic [DATA_W-1:0] dcache_dout;
  logic              dcache_val;
  logic              stall;
  logic              dcache_err;

  modport master (
    output dcache_addr, dcache_we, dcache_re, dcache_din,
    input  dcache_dout, dcache_val, stall, dcache_err
  );

  modport slave (
    input  dcache_addr, dcache_we, dcache_re, dcache_din,
    output dcache_dout, dcache_val, stall, dcache_err
  );
endinterface

// File: rtl/dmem_responder.sv
// Single-ported word memory answering core load/store requests after WAIT_STATES busy cycles.
// Optional DMEM_RESP_STATS_EN adds saturating load/store/stall counters.
module dmem_responder #(
  parameter int unsigned DEPTH_WORDS = 4096,
  parameter int unsigned WAIT_STATES = 2
) (
  input  logic              clk,
  input  logic              reset_n,
  dmem_responder_if.slave   bus
`ifdef DMEM_RESP_STATS_EN
  ,
  output logic [31:0]       stat_loads,
  output logic [31:0]       stat_stores,
  output logic [31:0]       stat_stalls
`endif
);

  localparam int unsigned IDX_W  = 30;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned BE_W   = 4;
  localparam int unsigned CNT_W  = 4;
  localparam int unsigned AW     = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam bit          HAS_WAIT = (WAIT_STATES != 0);
  localparam logic [CNT_W-1:0] CNT_LOAD  = HAS_WAIT ? CNT_W'(WAIT_STATES - 1) : '0;
  localparam logic [IDX_W:0]   DEPTH_LIM = DEPTH_WORDS[IDX_W:0];

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_e;

  state_e            state, state_nxt;
  logic [CNT_W-1:0]  cnt, cnt_nxt;
  logic              req_c, accept, fire, stall_c;

  logic [IDX_W-1:0]  cap_idx, cur_idx;
  logic [BE_W-1:0]   cap_we, cur_we;
  logic [DATA_W-1:0] cap_din, cur_din;

  logic [DATA_W-1:0] mem [DEPTH_WORDS];
  logic [AW-1:0]     mem_idx;
  logic [DATA_W-1:0] rd_word, merged;
  logic              in_range, is_store;

  logic [DATA_W-1:0] dout_q;
  logic              val_q, err_q;
  logic              addr_lsb_unused;

  assign req_c           = (|bus.dcache_we) | bus.dcache_re;
  assign addr_lsb_unused = ^bus.dcache_addr[1:0];

  // State register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= S_IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // Next state; RESP may accept the following request with no bubble
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    unique case (state)
      S_IDLE, S_RESP: begin
        if (req_c) begin
          state_nxt = HAS_WAIT ? S_WAIT : S_RESP;
          cnt_nxt   = CNT_LOAD;
        end else begin
          state_nxt = S_IDLE;
        end
      end
      S_WAIT: begin
        if (cnt == '0) state_nxt = S_RESP;
        else           cnt_nxt   = cnt - 1'b1;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // FSM outputs: accept/fire strobes and the combinational stall
  always_comb begin
    accept  = 1'b0;
    fire    = 1'b0;
    stall_c = 1'b0;
    accept  = ((state == S_IDLE) || (state == S_RESP)) && req_c;
    fire    = HAS_WAIT ? ((state == S_WAIT) && (cnt == '0)) : accept;
    stall_c = (accept && HAS_WAIT) || (state == S_WAIT);
  end

  // Request capture; with no wait states the response edge is the accept edge
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cap_idx <= '0;
      cap_we  <= '0;
      cap_din <= '0;
    end else if (accept) begin
      cap_idx <= bus.dcache_addr[31:2];
      cap_we  <= bus.dcache_we;
      cap_din <= bus.dcache_din;
    end
  end

  assign cur_idx  = HAS_WAIT ? cap_idx : bus.dcache_addr[31:2];
  assign cur_we   = HAS_WAIT ? cap_we  : bus.dcache_we;
  assign cur_din  = HAS_WAIT ? cap_din : bus.dcache_din;
  assign is_store = |cur_we;
  assign in_range = {1'b0, cur_idx} < DEPTH_LIM;
  assign mem_idx  = cur_idx[AW-1:0];
  assign rd_word  = mem[mem_idx];

  always_comb begin
    merged = rd_word;
    for (int i = 0; i < int'(BE_W); i++) begin
      if (cur_we[i]) merged[8*i +: 8] = cur_din[8*i +: 8];
    end
  end

  // Response registers; dout holds between responses
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      dout_q <= '0;
      val_q  <= 1'b0;
      err_q  <= 1'b0;
    end else begin
      val_q <= fire;
      err_q <= fire && !in_range;
      if (fire) dout_q <= in_range ? (is_store ? merged : rd_word) : '0;
    end
  end

  // Memory is not reset; writes blocked while reset is asserted
  always_ff @(posedge clk) begin
    if (reset_n && fire && is_store && in_range) mem[mem_idx] <= merged;
  end

  assign bus.dcache_dout = dout_q;
  assign bus.dcache_val  = val_q;
  assign bus.dcache_err  = err_q;
  assign bus.stall       = stall_c;

`ifdef DMEM_RESP_STATS_EN
  logic resp_store_q;

  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == '1) ? v : v + 32'd1;
  endfunction

  // Kind of the response currently presented, and saturating counters
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      resp_store_q <= 1'b0;
      stat_loads   <= '0;
      stat_stores  <= '0;
      stat_stalls  <= '0;
    end else begin
      if (fire) resp_store_q <= is_store;
      if (val_q) begin
        if (resp_store_q) stat_stores <= sat_inc(stat_stores);
        else              stat_loads  <= sat_inc(stat_loads);
      end
      if (stall_c) stat_stalls <= sat_inc(stat_stalls);
    end
  end
`endif

endmodule

// File: tb/tb_dmem_responder.sv
// Scoreboard bench: one responder with two wait states, one with none, checked against a word model.
module tb_dmem_responder;
  localparam int unsigned DEPTH = 4096;

  typedef struct {
    logic [31:0] dout;
    logic        err;
    int          due;
  } exp_t;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  dmem_responder_if bus2 ();
  dmem_responder_if bus0 ();

`ifdef DMEM_RESP_STATS_EN
  logic [31:0] s2_loads, s2_stores, s2_stalls;
  logic [31:0] s0_loads, s0_stores, s0_stalls;
  dmem_responder #(.DEPTH_WORDS(DEPTH), .WAIT_STATES(2)) u_dut_w2 (
    .clk(clk), .reset_n(reset_n), .bus(bus2),
    .stat_loads(s2_loads), .stat_stores(s2_stores), .stat_stalls(s2_stalls));
  dmem_responder #(.DEPTH_WORDS(DEPTH), .WAIT_STATES(0)) u_dut_w0 (
    .clk(clk), .reset_n(reset_n), .bus(bus0),
    .stat_loads(s0_loads), .stat_stores(s0_stores), .stat_stalls(s0_stalls));
`else
  dmem_responder #(.DEPTH_WORDS(DEPTH), .WAIT_STATES(2)) u_dut_w2 (
    .clk(clk), .reset_n(reset_n), .bus(bus2));
  dmem_responder #(.DEPTH_WORDS(DEPTH), .WAIT_STATES(0)) u_dut_w0 (
    .clk(clk), .reset_n(reset_n), .bus(bus0));
`endif

  int n_checks = 0;
  int n_pass   = 0;
  int cyc2 = 0;
  int cyc0 = 0;
  exp_t q2[$];
  exp_t q0[$];
  logic [31:0] m2 [logic [29:0]];
  logic [31:0] m0 [logic [29:0]];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [3:0] we,
                                        input logic [31:0] d);
    logic [31:0] r;
    r = old;
    for (int i = 0; i < 4; i++) if (we[i]) r[8*i +: 8] = d[8*i +: 8];
    return r;
  endfunction

  // Response monitors: data, error flag and arrival cycle against the scoreboard
  always @(negedge clk) begin : mon2
    exp_t e;
    cyc2++;
    if (bus2.dcache_val) begin
      if (q2.size() == 0) chk("w2_spurious_val", 32'd1, 32'd0);
      else begin
        e = q2.pop_front();
        chk("w2_dout", bus2.dcache_dout, e.dout);
        chk("w2_err", 32'(bus2.dcache_err), 32'(e.err));
        chk("w2_latency", 32'(cyc2), 32'(e.due));
      end
    end
  end

  always @(negedge clk) begin : mon0
    exp_t e;
    cyc0++;
    if (bus0.stall) chk("w0_stall", 32'd1, 32'd0);
    if (bus0.dcache_val) begin
      if (q0.size() == 0) chk("w0_spurious_val", 32'd1, 32'd0);
      else begin
        e = q0.pop_front();
        chk("w0_dout", bus0.dcache_dout, e.dout);
        chk("w0_err", 32'(bus0.dcache_err), 32'(e.err));
        chk("w0_latency", 32'(cyc0), 32'(e.due));
      end
    end
  end

  // One request on the two-wait-state responder; called just after a rising edge
  task automatic w2_op(input logic [31:0] a, input logic [3:0] we, input logic re,
                       input logic [31:0] d);
    exp_t e;
    logic [29:0] idx;
    logic [31:0] old;
    idx   = a[31:2];
    e.due = cyc2 + 4;
    e.err = (32'(idx) >= DEPTH);
    old   = m2.exists(idx) ? m2[idx] : 32'h0;
    if (e.err) e.dout = 32'h0;
    else if (|we) begin
      e.dout  = merge(old, we, d);
      m2[idx] = e.dout;
    end else e.dout = old;
    q2.push_back(e);
    bus2.dcache_addr = a; bus2.dcache_we = we; bus2.dcache_re = re; bus2.dcache_din = d;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("w2_stall_busy", 32'(bus2.stall), 32'd1);
      chk("w2_no_early_val", 32'(bus2.dcache_val), 32'd0);
    end
    bus2.dcache_we = '0; bus2.dcache_re = 1'b0;
    @(negedge clk);
    chk("w2_stall_at_val", 32'(bus2.stall), 32'd0);
    chk("w2_val_pulse", 32'(bus2.dcache_val), 32'd1);
    @(posedge clk); #1;
  endtask

  // One request per cycle on the zero-wait responder
  task automatic w0_issue(input logic [31:0] a, input logic [3:0] we, input logic re,
                          input logic [31:0] d);
    exp_t e;
    logic [29:0] idx;
    logic [31:0] old;
    idx   = a[31:2];
    e.due = cyc0 + 2;
    e.err = (32'(idx) >= DEPTH);
    old   = m0.exists(idx) ? m0[idx] : 32'h0;
    if (e.err) e.dout = 32'h0;
    else if (|we) begin
      e.dout  = merge(old, we, d);
      m0[idx] = e.dout;
    end else e.dout = old;
    q0.push_back(e);
    bus0.dcache_addr = a; bus0.dcache_we = we; bus0.dcache_re = re; bus0.dcache_din = d;
    @(posedge clk); #1;
  endtask

  initial begin
    bus2.dcache_addr = '0; bus2.dcache_we = '0; bus2.dcache_re = 1'b0; bus2.dcache_din = '0;
    bus0.dcache_addr = '0; bus0.dcache_we = '0; bus0.dcache_re = 1'b0; bus0.dcache_din = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_val", 32'(bus2.dcache_val), 32'd0);
    chk("rst_dout", bus2.dcache_dout, 32'h0);
    chk("rst_stall", 32'(bus2.stall), 32'd0);
    chk("rst_err", 32'(bus2.dcache_err), 32'd0);
    reset_n = 1'b1;
    @(posedge clk); #1;

    // Full store, partial store, load back, store with re also high
    w2_op(32'h10, 4'hF, 1'b0, 32'hDEAD_BEEF);
    w2_op(32'h10, 4'b0100, 1'b0, 32'h00AB_0000);
    w2_op(32'h10, 4'h0, 1'b1, 32'h0);
    chk("partial_merge_model", m2[30'h4], 32'hDEAB_BEEF);
    w2_op(32'h14, 4'hF, 1'b1, 32'hCAFE_F00D);
    w2_op(32'h15, 4'h0, 1'b1, 32'h0);

    // Out-of-range: loads return 0 with err; store must not alias onto word 0
    w2_op(32'h0, 4'hF, 1'b0, 32'h0123_4567);
    w2_op(DEPTH * 4, 4'h0, 1'b1, 32'h0);
    w2_op(DEPTH * 4, 4'hF, 1'b0, 32'hFFFF_FFFF);
    w2_op(32'h8000_0000, 4'h0, 1'b1, 32'h0);
    w2_op(32'h0, 4'h0, 1'b1, 32'h0);

    // Reset during the wait of a store: abandoned, memory keeps old word
    w2_op(32'h20, 4'hF, 1'b0, 32'h1111_1111);
    bus2.dcache_addr = 32'h20; bus2.dcache_we = 4'hF; bus2.dcache_din = 32'h2222_2222;
    @(negedge clk);
    @(negedge clk);
    chk("mid_req_stall", 32'(bus2.stall), 32'd1);
    reset_n = 1'b0;
    bus2.dcache_we = '0;
    #1;
    chk("mid_rst_stall", 32'(bus2.stall), 32'd0);
    chk("mid_rst_val", 32'(bus2.dcache_val), 32'd0);
    chk("mid_rst_dout", bus2.dcache_dout, 32'h0);
    @(posedge clk); #1;
    reset_n = 1'b1;
    @(posedge clk); #1;
    w2_op(32'h20, 4'h0, 1'b1, 32'h0);

    // Zero wait states: back-to-back requests, store-then-load forwarding
    w0_issue(32'h100, 4'hF, 1'b0, 32'hAAAA_0001);
    w0_issue(32'h104, 4'hF, 1'b0, 32'hBBBB_0002);
    w0_issue(32'h100, 4'h0, 1'b1, 32'h0);
    w0_issue(32'h104, 4'h0, 1'b1, 32'h0);
    w0_issue(32'h100, 4'hF, 1'b0, 32'hCCCC_0003);
    w0_issue(32'h100, 4'h0, 1'b1, 32'h0);
    w0_issue(32'h104, 4'b0001, 1'b0, 32'h0000_00EE);
    w0_issue(32'h104, 4'h0, 1'b1, 32'h0);
    w0_issue(DEPTH * 4 + 4, 4'h0, 1'b1, 32'h0);
    bus0.dcache_we = '0; bus0.dcache_re = 1'b0;
    repeat (3) @(posedge clk);
    #1;

`ifdef DMEM_RESP_STATS_EN
    // Counter check: 3 loads (one out of range) + 2 stores, 3 stall cycles each
    reset_n = 1'b0;
    @(posedge clk); #1;
    reset_n = 1'b1;
    @(posedge clk); #1;
    chk("stat_reset", s2_loads | s2_stores | s2_stalls, 32'h0);
    w2_op(32'h10, 4'h0, 1'b1, 32'h0);
    w2_op(32'h30, 4'hF, 1'b0, 32'h3333_3333);
    w2_op(32'h30, 4'h0, 1'b1, 32'h0);
    w2_op(DEPTH * 4, 4'h0, 1'b1, 32'h0);
    w2_op(32'h34, 4'b1000, 1'b0, 32'h4400_0000);
    chk("stat_loads", s2_loads, 32'd3);
    chk("stat_stores", s2_stores, 32'd2);
    chk("stat_stalls", s2_stalls, 32'd15);
    chk("stat_w0_stalls", s0_stalls, 32'd0);
`endif

    repeat (2) @(posedge clk);
    chk("w2_drained", 32'(q2.size()), 32'd0);
    chk("w0_drained", 32'(q0.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
